// File: rtl/lsu_dmem_pkg.sv
// Shared definitions for the RV32I load/store unit.
//   - funct3 width/sign encodings (F3_B, F3_H, F3_W, F3_BU, F3_HU)
//   - LSU FSM state encoding (IDLE, WAIT, DONE)
//   - helpers for access legality, byte-enable and store-lane generation
package lsu_dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } lsu_state_e;

    // An access is legal when funct3 names a width this direction supports
    // and the address is naturally aligned for that width.
    function automatic logic access_legal(input logic       st,
                                          input logic [2:0] f3,
                                          input logic [1:0] off);
        logic ok;
        ok = 1'b0;
        case (f3)
            F3_B:    ok = 1'b1;
            F3_H:    ok = ~off[0];
            F3_W:    ok = (off == 2'b00);
            F3_BU:   ok = ~st;
            F3_HU:   ok = ~st & ~off[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // funct3[1:0] carries the access size for both signed and unsigned loads.
    function automatic logic [3:0] lane_be(input logic [2:0] f3,
                                           input logic [1:0] off);
        logic [3:0] be;
        case (f3[1:0])
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Store data is replicated into every lane so the byte enables alone
    // select which bytes memory writes.
    function automatic logic [31:0] lane_wdata(input logic [2:0]  f3,
                                               input logic [31:0] data);
        logic [31:0] wd;
        case (f3[1:0])
            2'b00:   wd = {4{data[7:0]}};
            2'b01:   wd = {2{data[15:0]}};
            default: wd = data;
        endcase
        return wd;
    endfunction

endpackage

// File: rtl/lsu_dmem_if.sv
// Data-memory bus between the LSU (master) and data memory (slave).
//   dmem_req   master->slave  request valid, held until dmem_ack
//   dmem_we    master->slave  write enable
//   dmem_be    master->slave  byte enables
//   dmem_addr  master->slave  word-aligned byte address
//   dmem_wdata master->slave  lane-replicated store data
//   dmem_rdata slave->master  read word, valid in the dmem_ack cycle
//   dmem_ack   slave->master  access complete
// Handshake: a transfer completes in the cycle where dmem_req and dmem_ack
// are both high; the master keeps every request field stable from the first
// dmem_req cycle through that cycle. dmem_ack without dmem_req is ignored.
interface lsu_dmem_if #(
    parameter int ADDR_W = 32,
    parameter int XLEN   = 32
);
    logic                 dmem_req;
    logic                 dmem_we;
    logic [XLEN/8-1:0]    dmem_be;
    logic [ADDR_W-1:0]    dmem_addr;
    logic [XLEN-1:0]      dmem_wdata;
    logic [XLEN-1:0]      dmem_rdata;
    logic                 dmem_ack;

    modport master (
        output dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
        output dmem_rdata, dmem_ack
    );
endinterface

// File: rtl/lsu_load_align.sv
// Load formatter: picks the addressed byte/halfword out of a memory word and
// sign- or zero-extends it according to funct3. Purely combinational.
//   rdata  in   raw 32-bit word from memory
//   offset in   byte offset addr[1:0] of the access
//   funct3 in   RV32I load width/sign field
//   value  out  formatted 32-bit load result
module lsu_load_align
    import lsu_dmem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] value
);
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = rdata[{offset, 3'b000} +: 8];
        half_lane = offset[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_B:    value = {{24{byte_lane[7]}}, byte_lane};
            F3_BU:   value = {24'b0, byte_lane};
            F3_H:    value = {{16{half_lane[15]}}, half_lane};
            F3_HU:   value = {16'b0, half_lane};
            default: value = rdata;
        endcase
    end
endmodule

// File: rtl/lsu_dmem.sv
// RV32I load/store unit. Accepts a memory instruction (start), checks its
// legality, runs one req/ack transaction on the data-memory bus and returns
// the formatted, registered load value for the writeback mux.
//   clk, rst      clock, synchronous active-high reset
//   start         memory instruction presented this cycle
//   is_store      1 = store, 0 = load (sampled with start)
//   funct3        RV32I width/sign field
//   addr          effective address
//   store_data    rs2 value
//   mem_read      registered load result
//   stall         hold PC/pipeline while an access is in flight
//   done          one-cycle completion pulse
//   misaligned    one-cycle exception pulse (misaligned or illegal funct3)
//   state_dbg     current FSM state
//   dmem          data-memory bus (master side)
module lsu_dmem
    import lsu_dmem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int XLEN   = 32
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              is_store,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [XLEN-1:0]   store_data,
    output logic [XLEN-1:0]   mem_read,
    output logic              stall,
    output logic              done,
    output logic              misaligned,
    output lsu_state_e        state_dbg,
    lsu_dmem_if.master        dmem
);
    lsu_state_e  state;
    logic        legal;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [31:0] load_value;

    assign legal     = access_legal(is_store, funct3, addr[1:0]);
    assign state_dbg = state;

    // The start cycle must already hold the pipeline, so stall is not
    // registered; an illegal access never stalls.
    assign stall = (state == WAIT) || ((state == IDLE) && start && legal);

    // Formatting uses the offset/funct3 captured at start, since the core's
    // addr/funct3 inputs are free to change while we wait for memory.
    lsu_load_align u_align (
        .rdata  (dmem.dmem_rdata),
        .offset (off_q),
        .funct3 (f3_q),
        .value  (load_value)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            mem_read        <= '0;
            done            <= 1'b0;
            misaligned      <= 1'b0;
            f3_q            <= '0;
            off_q           <= '0;
            dmem.dmem_req   <= 1'b0;
            dmem.dmem_we    <= 1'b0;
            dmem.dmem_be    <= '0;
            dmem.dmem_addr  <= '0;
            dmem.dmem_wdata <= '0;
        end else begin
            done       <= 1'b0;
            misaligned <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (legal) begin
                            dmem.dmem_req   <= 1'b1;
                            dmem.dmem_we    <= is_store;
                            dmem.dmem_be    <= lane_be(funct3, addr[1:0]);
                            dmem.dmem_addr  <= {addr[ADDR_W-1:2], 2'b00};
                            dmem.dmem_wdata <= lane_wdata(funct3, store_data);
                            f3_q            <= funct3;
                            off_q           <= addr[1:0];
                            state           <= WAIT;
                        end else begin
                            misaligned <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (dmem.dmem_ack) begin
                        dmem.dmem_req <= 1'b0;
                        if (!dmem.dmem_we) begin
                            mem_read <= load_value;
                        end
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    // The core advances at the end of this cycle; a start
                    // seen here belongs to the instruction just completed.
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_dmem.sv
module tb_lsu_dmem;
    import lsu_dmem_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic [31:0] mem_read;
    logic        stall;
    logic        done;
    logic        misaligned;
    lsu_state_e  state_dbg;

    lsu_dmem_if #(.ADDR_W(32), .XLEN(32)) dmem_bus ();

    lsu_dmem #(.ADDR_W(32), .XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .is_store   (is_store),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .mem_read   (mem_read),
        .stall      (stall),
        .done       (done),
        .misaligned (misaligned),
        .state_dbg  (state_dbg),
        .dmem       (dmem_bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // scoreboard
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    logic [31:0] model_mem_read;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // reference model
    function automatic logic m_legal(input logic st, input logic [2:0] f3, input logic [31:0] a);
        logic ok;
        ok = (f3 == 3'b000) || (f3 == 3'b001 && a[0] == 1'b0) || (f3 == 3'b010 && a[1:0] == 2'b00);
        if (!st) ok = ok || (f3 == 3'b100) || (f3 == 3'b101 && a[0] == 1'b0);
        return ok;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        if (f3 == 3'b010) return 4'b1111;
        if (f3 == 3'b001 || f3 == 3'b101) return (a[1:0] == 2'b10) ? 4'b1100 : 4'b0011;
        case (a[1:0])
            2'b00:   return 4'b0001;
            2'b01:   return 4'b0010;
            2'b10:   return 4'b0100;
            default: return 4'b1000;
        endcase
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
        if (f3 == 3'b000) return {d[7:0], d[7:0], d[7:0], d[7:0]};
        if (f3 == 3'b001) return {d[15:0], d[15:0]};
        return d;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] rd, input logic [1:0] off, input logic [2:0] f3);
        logic [31:0] sh;
        sh = rd >> (int'(off) * 8);
        case (f3)
            3'b000:  return {{24{sh[7]}}, sh[7:0]};
            3'b100:  return {24'h0, sh[7:0]};
            3'b001:  return {{16{sh[15]}}, sh[15:0]};
            3'b101:  return {16'h0, sh[15:0]};
            default: return rd;
        endcase
    endfunction

    // driver: one complete instruction; memory acks on the n_req-th request cycle
    task automatic do_access(input logic st, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] sd, input logic [31:0] rd, input int n_req,
                             input logic hold_in_done, input string tag);
        logic        legal;
        logic [31:0] exp_v;
        int          cyc;
        int          stall_cyc;
        legal = m_legal(st, f3, a);
        @(negedge clk);
        start = 1'b1; is_store = st; funct3 = f3; addr = a; store_data = sd;
        #1;
        check({tag, "_stall_start"}, 32'(stall), 32'(legal));
        if (legal) exp_q.push_back(st ? model_mem_read : m_load(rd, a[1:0], f3));
        @(negedge clk);
        start = 1'b0;
        addr = $urandom; store_data = $urandom; funct3 = 3'($urandom_range(0, 7));
        is_store = 1'($urandom_range(0, 1));
        #1;
        if (!legal) begin
            check({tag, "_mis_pulse"}, 32'(misaligned), 32'd1);
            check({tag, "_mis_req"}, 32'(dmem_bus.dmem_req), 32'd0);
            check({tag, "_mis_stall"}, 32'(stall), 32'd0);
            check({tag, "_mis_memread"}, mem_read, model_mem_read);
            @(negedge clk);
            #1;
            check({tag, "_mis_once"}, 32'(misaligned), 32'd0);
            check({tag, "_mis_done"}, 32'(done), 32'd0);
            check({tag, "_mis_state"}, 32'(state_dbg), 32'(IDLE));
            return;
        end
        stall_cyc = 1;
        cyc = 0;
        while (cyc < n_req) begin
            cyc++;
            check({tag, "_req"}, 32'(dmem_bus.dmem_req), 32'd1);
            check({tag, "_addr"}, dmem_bus.dmem_addr, {a[31:2], 2'b00});
            check({tag, "_be"}, 32'(dmem_bus.dmem_be), 32'(m_be(f3, a)));
            check({tag, "_we"}, 32'(dmem_bus.dmem_we), 32'(st));
            if (st) check({tag, "_wdata"}, dmem_bus.dmem_wdata, m_wdata(f3, sd));
            if (stall) stall_cyc++;
            if (cyc == n_req) begin
                dmem_bus.dmem_ack = 1'b1;
                dmem_bus.dmem_rdata = rd;
            end else begin
                dmem_bus.dmem_ack = 1'b0;
                dmem_bus.dmem_rdata = $urandom;
            end
            @(negedge clk);
            #1;
        end
        dmem_bus.dmem_ack = 1'b0;
        dmem_bus.dmem_rdata = $urandom;
        if (hold_in_done) begin
            start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h0000_0500;
        end
        #1;
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_done_stall"}, 32'(stall), 32'd0);
        check({tag, "_done_req"}, 32'(dmem_bus.dmem_req), 32'd0);
        check({tag, "_stall_cycles"}, 32'(stall_cyc), 32'(n_req + 1));
        check({tag, "_sb_nonempty"}, 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            check({tag, "_mem_read"}, mem_read, exp_v);
            model_mem_read = exp_v;
        end
        @(negedge clk);
        start = 1'b0;
        #1;
        check({tag, "_done_once"}, 32'(done), 32'd0);
        check({tag, "_back_idle"}, 32'(state_dbg), 32'(IDLE));
        check({tag, "_idle_req"}, 32'(dmem_bus.dmem_req), 32'd0);
        check({tag, "_memread_hold"}, mem_read, model_mem_read);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; is_store = 1'b0; funct3 = 3'b000;
        addr = '0; store_data = '0;
        dmem_bus.dmem_ack = 1'b0; dmem_bus.dmem_rdata = '0;
        model_mem_read = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_mem_read", mem_read, 32'd0);
        check("rst_req", 32'(dmem_bus.dmem_req), 32'd0);
        check("rst_we", 32'(dmem_bus.dmem_we), 32'd0);
        check("rst_be", 32'(dmem_bus.dmem_be), 32'd0);
        check("rst_addr", dmem_bus.dmem_addr, 32'd0);
        check("rst_wdata", dmem_bus.dmem_wdata, 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_mis", 32'(misaligned), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(IDLE));
        rst = 1'b0;

        do_access(1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 3, 1'b0, "lw");
        do_access(1'b0, 3'b000, 32'h0000_0203, 32'h0, 32'h80FF_7F01, 1, 1'b0, "lb");
        do_access(1'b0, 3'b100, 32'h0000_0203, 32'h0, 32'h80FF_7F01, 2, 1'b0, "lbu");
        do_access(1'b1, 3'b000, 32'h0000_0302, 32'h0000_00A5, 32'hFFFF_FFFF, 1, 1'b0, "sb");
        do_access(1'b1, 3'b001, 32'h0000_0302, 32'h0000_1234, 32'hFFFF_FFFF, 2, 1'b0, "sh");
        do_access(1'b0, 3'b001, 32'h0000_0101, 32'h0, 32'h0, 1, 1'b0, "lh_mis");
        do_access(1'b1, 3'b010, 32'h0000_0102, 32'h5555_5555, 32'h0, 1, 1'b0, "sw_mis");
        do_access(1'b0, 3'b011, 32'h0000_0100, 32'h0, 32'h0, 1, 1'b0, "ld_f3_011");
        do_access(1'b1, 3'b100, 32'h0000_0100, 32'h0, 32'h0, 1, 1'b0, "st_f3_100");
        do_access(1'b0, 3'b001, 32'h0000_0102, 32'h0, 32'h8001_7FFF, 1, 1'b0, "lh_hi");
        do_access(1'b0, 3'b101, 32'h0000_0102, 32'h0, 32'h8001_7FFF, 4, 1'b0, "lhu_hi");
        do_access(1'b0, 3'b001, 32'h0000_0100, 32'h0, 32'h1234_8765, 2, 1'b0, "lh_lo");

        // ack while idle must be ignored
        @(negedge clk);
        dmem_bus.dmem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("idle_ack_done", 32'(done), 32'd0);
            check("idle_ack_state", 32'(state_dbg), 32'(IDLE));
        end
        dmem_bus.dmem_ack = 1'b0;

        // back-to-back: start held in DONE, then next load the cycle after DONE
        do_access(1'b0, 3'b010, 32'h0000_0600, 32'h0, 32'hCAFE_F00D, 1, 1'b1, "b2b_a");
        do_access(1'b0, 3'b000, 32'h0000_0601, 32'h0, 32'h0000_9C00, 1, 1'b0, "b2b_b");

        for (int i = 0; i < 24; i++) begin
            do_access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
                      $urandom, $urandom, $urandom_range(1, 4), 1'b0, "rand");
        end

        // reset during WAIT; the late ack must not complete anything
        @(negedge clk);
        start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h0000_0400;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("rstw_req_before", 32'(dmem_bus.dmem_req), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        dmem_bus.dmem_ack = 1'b1;
        dmem_bus.dmem_rdata = 32'h1234_5678;
        #1;
        check("rstw_req", 32'(dmem_bus.dmem_req), 32'd0);
        check("rstw_state", 32'(state_dbg), 32'(IDLE));
        check("rstw_mem_read", mem_read, 32'd0);
        check("rstw_stall", 32'(stall), 32'd0);
        @(negedge clk);
        dmem_bus.dmem_ack = 1'b0;
        #1;
        check("rstw_no_done", 32'(done), 32'd0);
        check("rstw_mem_read_hold", mem_read, 32'd0);
        check("rstw_req_after", 32'(dmem_bus.dmem_req), 32'd0);
        model_mem_read = '0;

        do_access(1'b0, 3'b010, 32'h0000_0404, 32'h0, 32'h0BAD_CAFE, 1, 1'b0, "post_rst");

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
